// File: rtl/wino_pkg.sv
// Shared types and sizes for the Winograd tile feeder.
package wino_pkg;

   typedef enum logic [1:0] {
      LOAD_INP = 2'd0,
      LOAD_KER = 2'd1,
      COMPUTE  = 2'd2,
      DRAIN    = 2'd3
   } state_t;

   localparam int INP_BYTES = 16;
   localparam int KER_BYTES = 9;
   localparam int OUT_BYTES = 4;

endpackage

// File: rtl/winograd.sv
// Combinational Winograd F(2x2,3x3) core: 4x4 tile correlated with a 3x3 kernel,
// four 8-bit results truncated modulo 256.
// The kernel transform is scaled by 2 on each side so everything stays integer;
// the x4 result is exact, so arithmetic modulo 2^10 followed by dropping the two
// LSBs yields the true result modulo 256.
module winograd (
   input  logic [7:0] inp10, inp11, inp12, inp13,
   input  logic [7:0] inp20, inp21, inp22, inp23,
   input  logic [7:0] inp30, inp31, inp32, inp33,
   input  logic [7:0] inp40, inp41, inp42, inp43,
   input  logic [7:0] ker10, ker11, ker12,
   input  logic [7:0] ker20, ker21, ker22,
   input  logic [7:0] ker30, ker31, ker32,
   output logic [7:0] out10, out11, out20, out21
);
   logic [127:0] d_flat;
   logic [71:0]  g_flat;
   logic [9:0]   d  [4][4];
   logic [9:0]   g  [3][3];
   logic [9:0]   bd [4][4];
   logic [9:0]   v  [4][4];
   logic [9:0]   gg [4][3];
   logic [9:0]   u  [4][4];
   logic [9:0]   m  [4][4];
   logic [9:0]   am [2][4];
   logic [9:0]   y  [2][2];
   logic         unused_lsbs;

   assign d_flat = {inp43, inp42, inp41, inp40, inp33, inp32, inp31, inp30,
                    inp23, inp22, inp21, inp20, inp13, inp12, inp11, inp10};
   assign g_flat = {ker32, ker31, ker30, ker22, ker21, ker20, ker12, ker11, ker10};

   for (genvar gi = 0; gi < 4; gi++) begin : g_d_row
      for (genvar gj = 0; gj < 4; gj++) begin : g_d_col
         assign d[gi][gj] = {2'b00, d_flat[(gi*4+gj)*8 +: 8]};
      end
   end
   for (genvar gi = 0; gi < 3; gi++) begin : g_k_row
      for (genvar gj = 0; gj < 3; gj++) begin : g_k_col
         assign g[gi][gj] = {2'b00, g_flat[(gi*3+gj)*8 +: 8]};
      end
   end

   // Input transform B^T d B, kernel transform (2G) g (2G)^T, product, output transform A^T M A
   always_comb begin
      for (int j = 0; j < 4; j++) begin
         bd[0][j] = d[0][j] - d[2][j];
         bd[1][j] = d[1][j] + d[2][j];
         bd[2][j] = d[2][j] - d[1][j];
         bd[3][j] = d[1][j] - d[3][j];
      end
      for (int i = 0; i < 4; i++) begin
         v[i][0] = bd[i][0] - bd[i][2];
         v[i][1] = bd[i][1] + bd[i][2];
         v[i][2] = bd[i][2] - bd[i][1];
         v[i][3] = bd[i][1] - bd[i][3];
      end
      for (int j = 0; j < 3; j++) begin
         gg[0][j] = g[0][j] << 1;
         gg[1][j] = g[0][j] + g[1][j] + g[2][j];
         gg[2][j] = g[0][j] - g[1][j] + g[2][j];
         gg[3][j] = g[2][j] << 1;
      end
      for (int i = 0; i < 4; i++) begin
         u[i][0] = gg[i][0] << 1;
         u[i][1] = gg[i][0] + gg[i][1] + gg[i][2];
         u[i][2] = gg[i][0] - gg[i][1] + gg[i][2];
         u[i][3] = gg[i][2] << 1;
         for (int j = 0; j < 4; j++) begin
            m[i][j] = u[i][j] * v[i][j];
         end
      end
      for (int j = 0; j < 4; j++) begin
         am[0][j] = m[0][j] + m[1][j] + m[2][j];
         am[1][j] = m[1][j] - m[2][j] - m[3][j];
      end
      for (int i = 0; i < 2; i++) begin
         y[i][0] = am[i][0] + am[i][1] + am[i][2];
         y[i][1] = am[i][1] - am[i][2] - am[i][3];
      end
   end

   assign out10 = y[0][0][9:2];
   assign out11 = y[0][1][9:2];
   assign out20 = y[1][0][9:2];
   assign out21 = y[1][1][9:2];

   // The two LSBs are always zero (result is exactly 4x the true value)
   assign unused_lsbs = ^{y[0][0][1:0], y[0][1][1:0], y[1][0][1:0], y[1][1][1:0]};

endmodule

// File: rtl/winograd_tile_feeder.sv
// Byte-stream front end for the Winograd core: loads a 4x4 tile and a 3x3 kernel,
// runs the core for one cycle and streams the four result bytes back out.
// Optional kernel caching is enabled with the WINO_KER_CACHE_EN macro.
module winograd_tile_feeder
   import wino_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int TILE_CNT_W = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [DATA_W-1:0]     s_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_W-1:0]     m_data,
   output logic                  m_last,
   input  logic                  ker_reload,
   output logic                  tile_done,
   output logic [TILE_CNT_W-1:0] tile_cnt
);
   state_t                state_q, state_d;
   logic [3:0]            inp_idx_q, inp_idx_d;
   logic [3:0]            ker_idx_q, ker_idx_d;
   logic [1:0]            out_idx_q, out_idx_d;
   logic [DATA_W-1:0]     inp_q [INP_BYTES];
   logic [DATA_W-1:0]     inp_d [INP_BYTES];
   logic [DATA_W-1:0]     ker_q [KER_BYTES];
   logic [DATA_W-1:0]     ker_d [KER_BYTES];
   logic [DATA_W-1:0]     res_q [OUT_BYTES];
   logic [DATA_W-1:0]     res_d [OUT_BYTES];
   logic [DATA_W-1:0]     core_out [OUT_BYTES];
   logic                  s_ready_q, s_ready_d;
   logic                  m_valid_q, m_valid_d;
   logic [DATA_W-1:0]     m_data_q, m_data_d;
   logic                  m_last_q, m_last_d;
   logic                  tile_done_q, tile_done_d;
   logic [TILE_CNT_W-1:0] tile_cnt_q, tile_cnt_d;
   logic                  need_ker;
   logic                  s_hs;
   logic                  m_hs;

`ifdef WINO_KER_CACHE_EN
   logic                  kernel_valid_q, kernel_valid_d;
   assign need_ker = !kernel_valid_q || ker_reload;
`else
   logic                  unused_ker_reload;
   assign need_ker          = 1'b1;
   assign unused_ker_reload = ker_reload;
`endif

   assign s_hs = s_valid && s_ready_q;
   assign m_hs = m_valid_q && m_ready;

   winograd u_core (
      .inp10(inp_q[0]),  .inp11(inp_q[1]),  .inp12(inp_q[2]),  .inp13(inp_q[3]),
      .inp20(inp_q[4]),  .inp21(inp_q[5]),  .inp22(inp_q[6]),  .inp23(inp_q[7]),
      .inp30(inp_q[8]),  .inp31(inp_q[9]),  .inp32(inp_q[10]), .inp33(inp_q[11]),
      .inp40(inp_q[12]), .inp41(inp_q[13]), .inp42(inp_q[14]), .inp43(inp_q[15]),
      .ker10(ker_q[0]),  .ker11(ker_q[1]),  .ker12(ker_q[2]),
      .ker20(ker_q[3]),  .ker21(ker_q[4]),  .ker22(ker_q[5]),
      .ker30(ker_q[6]),  .ker31(ker_q[7]),  .ker32(ker_q[8]),
      .out10(core_out[0]), .out11(core_out[1]), .out20(core_out[2]), .out21(core_out[3])
   );

   // Next-state, register loading and registered-output values
   always_comb begin
      state_d     = state_q;
      inp_idx_d   = inp_idx_q;
      ker_idx_d   = ker_idx_q;
      out_idx_d   = out_idx_q;
      inp_d       = inp_q;
      ker_d       = ker_q;
      res_d       = res_q;
      m_data_d    = m_data_q;
      m_last_d    = m_last_q;
      tile_done_d = 1'b0;
      tile_cnt_d  = tile_cnt_q;
`ifdef WINO_KER_CACHE_EN
      kernel_valid_d = kernel_valid_q;
`endif
      case (state_q)
         LOAD_INP: begin
            if (s_hs) begin
               inp_d[inp_idx_q] = s_data;
               inp_idx_d        = inp_idx_q + 4'd1;
               if (inp_idx_q == 4'(INP_BYTES - 1)) begin
                  state_d = need_ker ? LOAD_KER : COMPUTE;
               end
            end
         end
         LOAD_KER: begin
            if (s_hs) begin
               ker_d[ker_idx_q] = s_data;
               if (ker_idx_q == 4'(KER_BYTES - 1)) begin
                  ker_idx_d = 4'd0;
                  state_d   = COMPUTE;
`ifdef WINO_KER_CACHE_EN
                  kernel_valid_d = 1'b1;
`endif
               end else begin
                  ker_idx_d = ker_idx_q + 4'd1;
               end
            end
         end
         COMPUTE: begin
            res_d     = core_out;
            m_data_d  = core_out[0];
            m_last_d  = 1'b0;
            out_idx_d = 2'd0;
            state_d   = DRAIN;
         end
         DRAIN: begin
            if (m_hs) begin
               if (m_last_q) begin
                  out_idx_d   = 2'd0;
                  m_last_d    = 1'b0;
                  tile_done_d = 1'b1;
                  tile_cnt_d  = tile_cnt_q + TILE_CNT_W'(1);
                  state_d     = LOAD_INP;
               end else begin
                  out_idx_d = out_idx_q + 2'd1;
                  m_data_d  = res_q[out_idx_q + 2'd1];
                  m_last_d  = (out_idx_q == 2'(OUT_BYTES - 2));
               end
            end
         end
         default: state_d = LOAD_INP;
      endcase
      // Handshake flags follow the next state so they are registered yet never stale
      s_ready_d = (state_d == LOAD_INP) || (state_d == LOAD_KER);
      m_valid_d = (state_d == DRAIN);
   end

   // State and datapath registers, cleared immediately on reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= LOAD_INP;
         inp_idx_q   <= '0;
         ker_idx_q   <= '0;
         out_idx_q   <= '0;
         for (int i = 0; i < INP_BYTES; i++) inp_q[i] <= '0;
         for (int i = 0; i < KER_BYTES; i++) ker_q[i] <= '0;
         for (int i = 0; i < OUT_BYTES; i++) res_q[i] <= '0;
         s_ready_q   <= 1'b1;
         m_valid_q   <= 1'b0;
         m_data_q    <= '0;
         m_last_q    <= 1'b0;
         tile_done_q <= 1'b0;
         tile_cnt_q  <= '0;
`ifdef WINO_KER_CACHE_EN
         kernel_valid_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         inp_idx_q   <= inp_idx_d;
         ker_idx_q   <= ker_idx_d;
         out_idx_q   <= out_idx_d;
         inp_q       <= inp_d;
         ker_q       <= ker_d;
         res_q       <= res_d;
         s_ready_q   <= s_ready_d;
         m_valid_q   <= m_valid_d;
         m_data_q    <= m_data_d;
         m_last_q    <= m_last_d;
         tile_done_q <= tile_done_d;
         tile_cnt_q  <= tile_cnt_d;
`ifdef WINO_KER_CACHE_EN
         kernel_valid_q <= kernel_valid_d;
`endif
      end
   end

   assign s_ready   = s_ready_q;
   assign m_valid   = m_valid_q;
   assign m_data    = m_data_q;
   assign m_last    = m_last_q;
   assign tile_done = tile_done_q;
   assign tile_cnt  = tile_cnt_q;

endmodule
